bcd_bin: RTL and testbench
==========================

Name: bcd_bin

Overview:
- Sequential converter from a 3-digit packed BCD value (000–999) to a 10-bit unsigned binary value.
- Uses the iterative reverse double-dabble algorithm: shift right, then subtract 3 from any BCD digit ≥ 8.
- A one-cycle start strobe launches a conversion; the result is registered and held until the next completion.
- Sits between BCD-entry front ends (keypad/display logic) and binary arithmetic datapaths.

Parameters:
- NDIG, 3, number of BCD digits; input width = 4*NDIG.
- BW, 10, binary output width; must satisfy 2^BW > 10^NDIG − 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- St  input  1  start strobe, sampled only in IDLE
- bcd  input  12  packed BCD; [11:8]=hundreds, [7:4]=tens, [3:0]=units
- bin  output  10  converted binary result, registered, held between conversions
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bin is updated

Behaviour:
- Reset (async, rst=1): state=IDLE, bin=0, busy=0, done=0, internal shift registers and counter cleared. Reset asserted mid-conversion aborts it; bin returns to 0.
- States: IDLE, CONV, FIN.
- IDLE: if St=1 at a rising edge, load the bcd register from bcd, clear the bin shift register, set cnt=0, go to CONV, busy=1. If St=0, stay in IDLE; bin is held; bcd changes are ignored.
- CONV, each cycle:
  - shift {bcd_reg, bin_sr} right by 1 (bcd_reg LSB enters bin_sr MSB);
  - then every 4-bit digit of bcd_reg that is ≥ 8 has 3 subtracted;
  - cnt increments; after the BW-th shift go to FIN.
- FIN: bin <= bin_sr, done=1 for exactly this one cycle, busy=0, return to IDLE.
- Latency: St sampled at edge N; bin and done update at edge N+BW+1 (11 for the default).
- Back-to-back operation: St may be reasserted in the cycle after done, giving a throughput of one conversion per 12 cycles.
- St high while busy: ignored, no queuing.
- St held continuously: a new conversion starts on each return to IDLE.
- The bcd input is captured only at the start; later changes do not affect an in-flight conversion.
- Boundaries: 000 -> 0; 999 -> 999 (0x3E7); no overflow is possible for valid input.
- Without checking, a digit > 9 yields the algorithm's deterministic output, which has no meaning and is not flagged.

Optional Feature:
- Macro BCD_BIN_CHECK_EN.
- Defined:
  - adds output port err (1 bit, reset 0);
  - at load, if any digit > 9, err is set and the conversion still runs full length;
  - on done, bin is forced to 0 and err=1;
  - err stays valid until the next done, and clears on a valid conversion or on reset.
- Undefined: no err port, no digit checking, and behaviour exactly as in Behaviour.

Decomposition:
- Shared package bcd_pkg holds the state enum (IDLE/CONV/FIN), the constants NDIG, BW and DIG_W=4, and the per-digit correction threshold (8) and correction amount (3).
- One natural sub-module, bcd_digit_adj: a combinational 4-bit "if ≥ 8 subtract 3" cell, instantiated NDIG times.

Test Plan:
- Reset then idle: rst=1 with bcd=0x227 and St=0 -> bin=0, done=0, busy=0; releasing rst with St=0 keeps bin=0.
- Basic: bcd=0x227, St=1 for one cycle -> busy for 10 cycles, done pulse at edge 11, bin=227 (0x0E3).
- Back-to-back: 0x629 then 0x982, St pulsed right after each done -> bin=629 (0x275), then 982 (0x3D6).
- Ignored start: after the 982 result, bcd=0x331 with St=0 for 20 cycles -> bin stays 982 and done never pulses; St pulsed during busy is ignored.
- Boundary and abort: 0x000 -> 0; 0x999 -> 999; rst pulsed at cycle 5 of a conversion -> bin=0, state IDLE, no done.
- BCD_BIN_CHECK_EN: bcd=0x2A7 -> done with err=1 and bin=0; a following 0x227 -> err=0, bin=227.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD-to-binary converter:
//   - converter FSM state encoding (IDLE / CONV / FIN)
//   - default digit count NDIG and binary width BW
//   - BCD digit width DIG_W and the reverse double-dabble correction constants
//   - digit_invalid(): true for a 4-bit code that is not a decimal digit
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int NDIG  = 3;
    localparam int BW    = 10;
    localparam int DIG_W = 4;

    // After each right shift, a digit that received a carried-in bit from the
    // digit above holds value+8; subtracting 3 turns that 8 into the decimal 5
    // that the shifted-in tens bit is actually worth.
    localparam logic [DIG_W-1:0] ADJ_THR = 4'd8;
    localparam logic [DIG_W-1:0] ADJ_AMT = 4'd3;
    localparam logic [DIG_W-1:0] MAX_DIG = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIG_W-1:0] d);
        return (d > MAX_DIG);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational correction cell for one BCD digit of the reverse double-dabble
// converter: if the digit is >= 8, subtract 3; otherwise pass it through.
//
// Ports:
//   d_i  in   DIG_W  digit value after the right shift
//   d_o  out  DIG_W  corrected digit value
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] d_i,
    output logic [DIG_W-1:0] d_o
);

    assign d_o = (d_i >= ADJ_THR) ? (d_i - ADJ_AMT) : d_i;

endmodule

// File: rtl/bcd_bin.sv
// -----------------------------------------------------------------------------
// bcd_bin
// Sequential packed-BCD to unsigned binary converter using the iterative
// reverse double-dabble algorithm (shift right, then subtract 3 from every
// BCD digit >= 8). A one-cycle start strobe in IDLE launches a conversion of
// BW shifts; the result is registered and held until the next completion.
//
// Optional build macro: BCD_BIN_CHECK_EN
//   When defined, adds output err. Any non-decimal digit at load time marks
//   the conversion bad; it still runs full length, but on completion bin is
//   forced to 0 and err is set. err holds until the next done or reset.
//
// Ports:
//   clk   in   1        rising-edge clock
//   rst   in   1        asynchronous active-high reset
//   St    in   1        start strobe, sampled only in IDLE
//   bcd   in   4*NDIG   packed BCD, most significant digit in the top nibble
//   bin   out  BW       converted result, registered, held between conversions
//   busy  out  1        high while shifting (CONV state)
//   done  out  1        one-cycle pulse when bin is updated
//   err   out  1        (BCD_BIN_CHECK_EN only) last result came from bad BCD
//
// BW must satisfy 2^BW > 10^NDIG - 1 so that every valid input fits.
// -----------------------------------------------------------------------------
module bcd_bin
    import bcd_pkg::*;
#(
    parameter int NDIG = bcd_pkg::NDIG,
    parameter int BW   = bcd_pkg::BW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  St,
    input  logic [DIG_W*NDIG-1:0] bcd,
    output logic [BW-1:0]         bin,
    output logic                  busy,
    output logic                  done
`ifdef BCD_BIN_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int DW = DIG_W * NDIG;
    localparam int CW = $clog2(BW + 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BW-1:0]   bin_sr_q, bin_sr_d;
    logic [BW-1:0]   bin_q, bin_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    // One step of the algorithm: shift the concatenation right by one, then
    // correct every digit of the upper (BCD) part.
    logic [DW-1:0]   shifted_bcd;
    logic [BW-1:0]   shifted_bin;
    logic [DW-1:0]   adj_bcd;

    assign {shifted_bcd, shifted_bin} = {bcd_sr_q, bin_sr_q} >> 1;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (shifted_bcd[g*DIG_W +: DIG_W]),
            .d_o (adj_bcd[g*DIG_W +: DIG_W])
        );
    end

`ifdef BCD_BIN_CHECK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;
    logic any_bad;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_invalid(bcd[i*DIG_W +: DIG_W])) begin
                any_bad = 1'b1;
            end
        end
    end
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef BCD_BIN_CHECK_EN
        bad_d    = bad_q;
        err_d    = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (St) begin
                    bcd_sr_d = bcd;
                    bin_sr_d = '0;
                    cnt_d    = '0;
`ifdef BCD_BIN_CHECK_EN
                    bad_d    = any_bad;
`endif
                    state_d  = CONV;
                end
            end

            CONV: begin
                bcd_sr_d = adj_bcd;
                bin_sr_d = shifted_bin;
                cnt_d    = cnt_q + 1'b1;
                // cnt_q counts completed shifts; this cycle performs shift cnt_q+1
                if (cnt_q == CW'(BW - 1)) begin
                    state_d = FIN;
                end
            end

            FIN: begin
`ifdef BCD_BIN_CHECK_EN
                bin_d = bad_q ? '0 : bin_sr_q;
                err_d = bad_q;
`else
                bin_d = bin_sr_q;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers; reset aborts any conversion and clears the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

`ifdef BCD_BIN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign bin  = bin_q;
    assign done = done_q;
    assign busy = (state_q == CONV);

endmodule

// File: tb/tb_bcd_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd_bin
// Self-checking bench for bcd_bin: directed reset/idle, latency, back-to-back,
// ignored-start, boundary and abort steps, plus randomized valid BCD values
// checked against a decimal-weight reference model.
// -----------------------------------------------------------------------------
module tb_bcd_bin;

    logic        clk;
    logic        rst;
    logic        St;
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
`ifdef BCD_BIN_CHECK_EN
    logic        err;
`endif

    int n_vec;
    int n_err;

    bcd_bin dut (
        .clk  (clk),
        .rst  (rst),
        .St   (St),
        .bcd  (bcd),
        .bin  (bin),
        .busy (busy),
        .done (done)
`ifdef BCD_BIN_CHECK_EN
        ,
        .err  (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: value of a packed BCD word from decimal digit weights
    function automatic int bcd_value(input logic [11:0] v);
        int h, t, u;
        h = int'(v[11:8]);
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        return h * 100 + t * 10 + u;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse St for one cycle with value v, then wait (bounded) for done.
    // Checks latency, busy length, single-cycle done width (on the start tick)
    // and the result against the reference.
    task automatic convert(input string tag, input logic [11:0] v, input int exp_bin);
        int lat;
        int busy_cnt;
        bcd = v;
        St  = 1'b1;
        tick();
        St  = 1'b0;
        chk({tag, "_done_low_at_start"}, done, 0);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (!done && busy) busy_cnt++;
        end
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_busy_cycles"}, busy_cnt, 10);
        chk({tag, "_bin"}, bin, exp_bin);
    endtask

    initial begin
        int dones;
        logic [11:0] rv;
        n_vec = 0;
        n_err = 0;

        // Reset with live-looking inputs
        rst = 1'b1;
        St  = 1'b0;
        bcd = 12'h227;
        repeat (3) tick();
        chk("rst_bin", bin, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_bin", bin, 0);
        chk("idle_busy", busy, 0);

        // Basic conversion
        convert("basic", 12'h227, 227);

        // Back-to-back: St pulsed in the cycle right after each done
        convert("b2b_a", 12'h629, 629);
        convert("b2b_b", 12'h982, 982);

        // Ignored start: St low, bcd changing
        bcd = 12'h331;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("noSt_dones", dones, 0);
        chk("noSt_bin", bin, 982);

        // St pulse while busy must not queue a second conversion
        bcd = 12'h415;
        St  = 1'b1;
        tick();
        St  = 1'b0;
        repeat (3) tick();
        bcd = 12'h777;
        St  = 1'b1;
        tick();
        St  = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                dones++;
                chk("busySt_bin", bin, 415);
            end
        end
        chk("busySt_dones", dones, 1);

        // Boundaries
        convert("zero", 12'h000, 0);
        convert("max", 12'h999, 999);

        // Randomized valid digits
        for (int i = 0; i < 8; i++) begin
            rv[11:8] = 4'($urandom_range(0, 9));
            rv[7:4]  = 4'($urandom_range(0, 9));
            rv[3:0]  = 4'($urandom_range(0, 9));
            convert("rand", rv, bcd_value(rv));
        end

        // Held St: consecutive conversions every 12 cycles
        convert("pre_held", 12'h123, 123);
        bcd = 12'h456;
        St  = 1'b1;
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done) begin
                dones++;
                chk("held_bin", bin, 456);
            end
        end
        St = 1'b0;
        chk("held_dones", dones, 2);
        repeat (14) tick();

        // Abort: reset asynchronously during cycle 5 of a conversion
        convert("pre_abort", 12'h864, 864);
        bcd = 12'h999;
        St  = 1'b1;
        tick();
        St  = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_bin", bin, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_bin_held", bin, 0);

`ifdef BCD_BIN_CHECK_EN
        convert("bad_digit", 12'h2A7, 0);
        chk("bad_err", err, 1);
        convert("good_after_bad", 12'h227, 227);
        chk("good_err", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

endmodule
